// File: rtl/dump_pkg.sv
// Shared types for the architectural-state dump engine.
// Contents: beat source encodings, FSM state enum, beat payload struct.
// Beat data is carried at BEAT_DATA_W bits; narrower DATA_W values are zero-extended.
package dump_pkg;

  localparam int unsigned SEL_W       = 2;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned BEAT_DATA_W = 64;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_REG  = 2'd0;
  localparam sel_t SEL_MEM  = 2'd1;
  localparam sel_t SEL_CSUM = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REG   = 3'd1,
    MEM   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    sel_t                   sel;
    logic [IDX_W-1:0]       idx;
    logic [BEAT_DATA_W-1:0] data;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/dump_skid_buf.sv
// Two-entry FIFO of beats. Entry 0 is always the head, so the head fields
// come straight from flops.
// Ports: clk, rst_n; push/push_beat (write), pop (head consumed);
//        head/head_valid (oldest entry), occ_c (entries held, 0..2).
module dump_skid_buf
  import dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic       head_valid,
  output logic [1:0] occ_c
);

  beat_t ent0;
  beat_t ent1;
  logic  v0;
  logic  v1;
  logic  pop_eff;

  assign pop_eff    = pop & v0;
  assign head       = ent0;
  assign head_valid = v0;
  // v1 implies v0, so two bits encode 0/1/2 directly
  assign occ_c      = {v1, v0 & ~v1};

  // Shift-style update: entry 1 moves to the head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      v0   <= 1'b0;
      v1   <= 1'b0;
    end else if (pop_eff) begin
      if (v1) begin
        ent0 <= ent1;
        v0   <= 1'b1;
        if (push) begin
          ent1 <= push_beat;
          v1   <= 1'b1;
        end else begin
          v1   <= 1'b0;
        end
      end else if (push) begin
        ent0 <= push_beat;
        v0   <= 1'b1;
      end else begin
        v0   <= 1'b0;
      end
    end else if (push) begin
      if (!v0) begin
        ent0 <= push_beat;
        v0   <= 1'b1;
      end else begin
        ent1 <= push_beat;
        v1   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/state_dump_reader.sv
// Dumps NUM_REGS register-file entries then NUM_MEM data-memory words as
// tagged beats on a valid/ready stream.
// Optional feature macro: DUMP_CHECKSUM_EN appends an XOR checksum beat.
// Ports: clk, rst_n, start (pulse, sampled in IDLE), busy, done (pulse);
//        rf_raddr/rf_rdata and dm_re/dm_raddr/dm_rdata (read data is sampled
//        on the edge after the address is presented);
//        out_valid/out_ready/out_sel/out_idx/out_data/out_last (beat stream).
module state_dump_reader
  import dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_MEM  = 32,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 rf_raddr,
  input  logic [DATA_W-1:0]          rf_rdata,
  output logic                       dm_re,
  output logic [$clog2(NUM_MEM)-1:0] dm_raddr,
  input  logic [DATA_W-1:0]          dm_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_sel,
  output logic [5:0]                 out_idx,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last
);

  localparam int unsigned MEM_AW = $clog2(NUM_MEM);
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NUM_MEM - 1);

  state_t            state, next_state;
  logic [IDX_W-1:0]  issue_idx, idx_d;
  logic              issue;
  sel_t              issue_sel;
  logic              issue_last;

  logic              inflight;
  sel_t              infl_sel;
  logic [IDX_W-1:0]  infl_idx;
  logic              infl_last;

  logic              busy_d, done_d;
  logic [4:0]        rf_raddr_d;
  logic              dm_re_d;
  logic [MEM_AW-1:0] dm_raddr_d;

  beat_t             push_beat;
  beat_t             head;
  logic              head_valid;
  logic [1:0]        occ;
  logic              pop;
  logic              slot_ok;

`ifdef DUMP_CHECKSUM_EN
  logic [BEAT_DATA_W-1:0] csum;
  logic                   csum_sent, csum_sent_d;
`endif

  assign pop = head_valid & out_ready;
  // occ + inflight - pop < 2, rearranged to avoid unsigned underflow
  assign slot_ok = (3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop));

  assign out_valid = head_valid;
  assign out_sel   = head.sel;
  assign out_idx   = head.idx;
  assign out_data  = DATA_W'(head.data);
  assign out_last  = head.last;

  // Next-state, issue decision and registered-output next values.
  always_comb begin
    next_state = state;
    idx_d      = issue_idx;
    issue      = 1'b0;
    issue_sel  = SEL_REG;
    issue_last = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_sent_d = csum_sent;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = REG;
          idx_d      = '0;
`ifdef DUMP_CHECKSUM_EN
          csum_sent_d = 1'b0;
`endif
        end
      end
      REG: begin
        if (slot_ok) begin
          issue     = 1'b1;
          issue_sel = SEL_REG;
          if (issue_idx == LAST_REG) begin
            next_state = MEM;
            idx_d      = '0;
          end else begin
            idx_d = issue_idx + IDX_W'(1);
          end
        end
      end
      MEM: begin
        if (slot_ok) begin
          issue     = 1'b1;
          issue_sel = SEL_MEM;
          if (issue_idx == LAST_MEM) begin
            next_state = DRAIN;
            idx_d      = '0;
`ifndef DUMP_CHECKSUM_EN
            issue_last = 1'b1;
`endif
          end else begin
            idx_d = issue_idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
`ifdef DUMP_CHECKSUM_EN
        // checksum beat rides the pipeline as a pseudo-read
        if (!csum_sent && slot_ok) begin
          issue       = 1'b1;
          issue_sel   = SEL_CSUM;
          issue_last  = 1'b1;
          csum_sent_d = 1'b1;
        end
`endif
        // last beat handshaking implies nothing remains in flight or buffered
        if (pop && head.last) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase

    busy_d = ((state == REG) || (state == MEM) || (state == DRAIN)) &&
             (next_state != DONE);
    done_d = (next_state == DONE);

    rf_raddr_d = rf_raddr;
    dm_raddr_d = dm_raddr;
    dm_re_d    = 1'b0;
    if (issue && (state == REG)) rf_raddr_d = 5'(issue_idx);
    if (issue && (state == MEM)) begin
      dm_re_d    = 1'b1;
      dm_raddr_d = MEM_AW'(issue_idx);
    end
  end

  // Landing read: tag with the issue-time sel/idx/last.
  always_comb begin
    push_beat      = '0;
    push_beat.sel  = infl_sel;
    push_beat.idx  = infl_idx;
    push_beat.last = infl_last;
    case (infl_sel)
      SEL_MEM:  push_beat.data = BEAT_DATA_W'(dm_rdata);
`ifdef DUMP_CHECKSUM_EN
      SEL_CSUM: push_beat.data = csum;
`endif
      default:  push_beat.data = BEAT_DATA_W'(rf_rdata);
    endcase
  end

  // State, issue pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_idx <= '0;
      inflight  <= 1'b0;
      infl_sel  <= SEL_REG;
      infl_idx  <= '0;
      infl_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rf_raddr  <= '0;
      dm_re     <= 1'b0;
      dm_raddr  <= '0;
    end else begin
      state     <= next_state;
      issue_idx <= idx_d;
      inflight  <= issue;
      if (issue) begin
        infl_sel  <= issue_sel;
        infl_idx  <= issue_idx;
        infl_last <= issue_last;
      end
      busy     <= busy_d;
      done     <= done_d;
      rf_raddr <= rf_raddr_d;
      dm_re    <= dm_re_d;
      dm_raddr <= dm_raddr_d;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Running XOR over every data beat entering the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum      <= '0;
      csum_sent <= 1'b0;
    end else begin
      csum_sent <= csum_sent_d;
      if ((state == IDLE) && start) csum <= '0;
      else if (inflight && (infl_sel != SEL_CSUM)) csum <= csum ^ push_beat.data;
    end
  end
`endif

  dump_skid_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .push_beat  (push_beat),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .occ_c      (occ)
  );

endmodule

// File: tb/tb_state_dump_reader.sv
// Scoreboard bench for state_dump_reader: stimulus pushes expected beats,
// a negedge monitor pops and compares each handshaked beat.
module tb_state_dump_reader;
  import dump_pkg::*;

  localparam int unsigned NR = 32;
  localparam int unsigned NM = 32;
  localparam int unsigned DW = 64;
`ifdef DUMP_CHECKSUM_EN
  localparam int NBEATS = NR + NM + 1;
`else
  localparam int NBEATS = NR + NM;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done;
  logic [4:0]    rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          dm_re;
  logic [4:0]    dm_raddr;
  logic [DW-1:0] dm_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_sel;
  logic [5:0]    out_idx;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic [DW-1:0] regs_m [NR];
  logic [DW-1:0] mem_m  [NM];

  assign rf_rdata = regs_m[rf_raddr];
  assign dm_rdata = dm_re ? mem_m[dm_raddr] : '0;

  state_dump_reader #(.NUM_REGS(NR), .NUM_MEM(NM), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dm_re(dm_re), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    total = 0;
  int    bad   = 0;
  int    beats, done_cnt, first_valid_rel, done_rel, last_rel, start_mark;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: sample at negedge, compare on handshake, enforce stall stability.
  initial begin
    logic          prev_stall;
    logic [8:0]    prev_tag;
    logic [DW-1:0] prev_data;
    beat_t         e;
    int            rel;
    prev_stall = 1'b0;
    prev_tag   = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      rel = cyc - start_mark;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_tag", 64'({out_sel, out_idx, out_last}), 64'(prev_tag));
          chk("stall_data", out_data, prev_data);
        end
        if (done) begin
          done_cnt++;
          if (done_rel < 0) done_rel = rel;
          chk("busy_at_done", 64'(busy), 64'd0);
        end
        if (out_valid && first_valid_rel < 0) first_valid_rel = rel;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat actual sel=%0d idx=%0d required none", out_sel, out_idx);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat%0d_sel", beats), 64'(out_sel), 64'(e.sel));
            chk($sformatf("beat%0d_idx", beats), 64'(out_idx), 64'(e.idx));
            chk($sformatf("beat%0d_data", beats), out_data, e.data);
            chk($sformatf("beat%0d_last", beats), 64'(out_last), 64'(e.last));
          end
          if (out_last) last_rel = rel;
          beats++;
        end
        prev_stall = out_valid && !out_ready;
        prev_tag   = {out_sel, out_idx, out_last};
        prev_data  = out_data;
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_sel"},   64'(out_sel), 64'd0);
    chk({tag, "_out_idx"},   64'(out_idx), 64'd0);
    chk({tag, "_out_data"},  out_data, 64'd0);
    chk({tag, "_out_last"},  64'(out_last), 64'd0);
    chk({tag, "_rf_raddr"},  64'(rf_raddr), 64'd0);
    chk({tag, "_dm_re"},     64'(dm_re), 64'd0);
    chk({tag, "_dm_raddr"},  64'(dm_raddr), 64'd0);
  endtask

  task automatic push_expected();
    beat_t         b;
    logic [DW-1:0] x;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < int'(NR); i++) begin
      b = '{sel: SEL_REG, idx: 6'(i), data: 64'(3 * i), last: 1'b0};
      x = x ^ b.data;
      exp_q.push_back(b);
    end
    for (int i = 0; i < int'(NM); i++) begin
      b = '{sel: SEL_MEM, idx: 6'(i), data: ~(64'(i)), last: 1'b0};
`ifndef DUMP_CHECKSUM_EN
      if (i == int'(NM) - 1) b.last = 1'b1;
`endif
      x = x ^ b.data;
      exp_q.push_back(b);
    end
`ifdef DUMP_CHECKSUM_EN
    b = '{sel: SEL_CSUM, idx: 6'd0, data: x, last: 1'b1};
    exp_q.push_back(b);
`endif
  endtask

  // mode: 0 ready=1, 1 toggling ready, 2 stall at beat 20,
  //       3 start while busy, 4 reset at beat 30
  task automatic run_dump(input int mode);
    int  rel;
    int  tail;
    bit  stalled;
    beats = 0; done_cnt = 0; first_valid_rel = -1; done_rel = -1; last_rel = -1;
    tail = -1; stalled = 1'b0;
    push_expected();
    @(posedge clk); #1;
    out_ready  = 1'b1;
    start      = 1'b1;
    start_mark = cyc + 1;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      rel   = cyc - start_mark;
      start = (mode == 3 && rel == 9);
      if (mode == 0 && rel == 0) chk("busy_cycle0", 64'(busy), 64'd0);
      if (mode == 0 && rel == 1) begin
        chk("busy_cycle1", 64'(busy), 64'd1);
        chk("rf_raddr_cycle1", 64'(rf_raddr), 64'd0);
      end
      if (mode == 1) out_ready = ~out_ready;
      if (mode == 2 && beats == 20 && !stalled) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          chk("long_stall_valid", 64'(out_valid), 64'd1);
          chk("long_stall_data", out_data, 64'd60);
          @(posedge clk); #1;
        end
        chk("long_stall_reads_le22", 64'(rf_raddr <= 5'd22), 64'd1);
        out_ready = 1'b1;
      end
      if (mode == 4 && beats == 30) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (done_rel >= 0 && tail < 0) tail = 20;
      if (tail > 0) tail--;
      if (tail == 0) break;
    end
    start = 1'b0;
    if (done_rel < 0) begin
      total++;
      bad++;
      $display("FAIL timeout_mode%0d actual=no_done required=done", mode);
    end
    chk($sformatf("beat_count_mode%0d", mode), 64'(beats), 64'(NBEATS));
    chk($sformatf("done_pulses_mode%0d", mode), 64'(done_cnt), 64'd1);
    chk($sformatf("leftover_mode%0d", mode), 64'(exp_q.size()), 64'd0);
    if (mode == 0) begin
      chk("first_valid_cycle", 64'(first_valid_rel), 64'd2);
      chk("last_beat_cycle", 64'(last_rel), 64'(NBEATS + 1));
      chk("done_cycle", 64'(done_rel), 64'(NBEATS + 2));
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NR); i++) regs_m[i] = 64'(3 * i);
    for (int i = 0; i < int'(NM); i++) mem_m[i] = ~(64'(i));
    start_mark = 0;
    beats = 0; done_cnt = 0; first_valid_rel = -1; done_rel = -1; last_rel = -1;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_dump(0);
    run_dump(1);
    run_dump(2);
    run_dump(3);
    run_dump(4);
    run_dump(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/state_dump_reader.md
# state_dump_reader

Read-back engine that extracts processor architectural state after a program run. On a start pulse it sequentially reads all 32 integer registers, then the first NUM_MEM data-memory words, and streams them out as tagged beats on a valid/ready interface. It sits beside `top`, attached to a dedicated read port on the register file and the data memory, and is the read side of the instruction-load path (`in_enable` / `Addr` / `in_instruc`). Benches and a future host link use it to dump state without hierarchical peeks.

## Interface
Parameters:
- NUM_REGS, 32: register-file entries dumped. Must be a power of two, at most 32.
- NUM_MEM, 32: data-memory words dumped. Must be a power of two, at least 2.
- DATA_W, 64: word width.

Ports:
- clk  in  1  rising-edge clock; the single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until `done`.
- done  out  1  one-cycle pulse after the final beat handshakes.
- rf_raddr  out  5  register read address.
- rf_rdata  in  DATA_W  register data. Valid one cycle after `rf_raddr`.
- dm_re  out  1  data-memory read enable.
- dm_raddr  out  log2(NUM_MEM)  word index.
- dm_rdata  in  DATA_W  memory data. Valid one cycle after `dm_re`.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_sel  out  2  beat source: 0 = register, 1 = memory, 2 = checksum.
- out_idx  out  6  register or word index.
- out_data  out  DATA_W  beat payload.
- out_last  out  1  final beat of the dump.

## Operation
- FSM states: IDLE, REG, MEM, DRAIN, DONE.
- IDLE
  - `start` = 1 moves to REG. The issue index and the checksum are cleared.
- REG
  - Issues `rf_raddr` = 0..NUM_REGS-1, one per issue slot.
  - After issuing NUM_REGS-1, moves to MEM.
- MEM
  - Issues `dm_re`=1 with `dm_raddr` = 0..NUM_MEM-1.
  - After the last issue, moves to DRAIN.
- DRAIN
  - Waits until the in-flight read has landed, the skid buffer is empty, and the final beat has handshaked.
  - Then moves to DONE.
- DONE
  - Pulses `done` for one cycle, clears `busy`, and returns to IDLE.
- Issue slot: a read is issued only when (buffer occupancy + in-flight reads − pops this cycle) < 2. This means a returning read always has a free entry.
- Read data is captured, tagged with the sel/idx of its issue, into a 2-entry FIFO skid buffer. `out_*` come from the buffer head.
- Handshake rules:
  - A beat transfers when `out_valid` && `out_ready`.
  - While `out_valid` = 1 and `out_ready` = 0, every `out_*` signal is held stable.
  - `out_valid` never drops without a transfer.
- Ordering: beats leave in issue order. No beat is dropped or duplicated.
- `out_last` is asserted only on the final beat of the dump.
- `start` while busy is ignored and has no effect.
- Reset
  - Asynchronous `rst_n` = 0 at any point forces IDLE, empties the buffer and cancels in-flight reads.
  - Reset values: all outputs 0, including `busy`, `done`, `out_valid`, `out_sel`, `out_idx`, `out_data`, `out_last`, `rf_raddr`, `dm_re` and `dm_raddr`.
- Index counters never wrap. Terminal counts are compared explicitly, with no reliance on overflow.

## Timing
- Cycle numbering: cycle 0 is the edge that samples `start` = 1 in IDLE.
- Cycle 1: `busy` = 1 and the first `rf_raddr` = 0 is presented.
- Cycle 2: first `out_valid`, carrying register 0.
- With `out_ready` held at 1, throughput is one beat per cycle and no bubbles occur at the register/memory boundary.
- With `out_ready` held at 1, the final beat is presented at cycle NUM_REGS+NUM_MEM+1, which is 65 with the default parameters.
- `done` = 1 in the cycle after the final handshake. `busy` = 0 in that same cycle.
- Read latency is fixed at 1 cycle for both ports. `dm_re` is high only in issue cycles.

## Configuration
- Macro `DUMP_CHECKSUM_EN`.
- When defined:
  - After the last memory beat, one extra beat is sent with `out_sel` = 2, `out_idx` = 0, and `out_data` = XOR of all prior `out_data` values.
  - `out_last` moves to this checksum beat.
  - All timing above shifts by one cycle.
- When undefined:
  - No checksum logic exists.
  - `out_sel` never equals 2.
  - The last memory beat carries `out_last`.

## Structure
- Package `dump_pkg` holds:
  - the `out_sel` encodings (SEL_REG, SEL_MEM, SEL_CSUM);
  - the FSM state enum;
  - the beat struct {sel, idx, data, last}.
- Sub-module `dump_skid_buf`: a 2-entry FIFO of beat structs with push, pop, occupancy and head output. The occupancy output drives the issue-slot check.

## Test plan
- Baseline dump: preload register x[i] = 3·i and mem[i] = ~i. Hold `out_ready` = 1 and pulse `start`.
  - Expect 64 beats: beats 0..31 have sel 0, idx i, data 3·i; beats 32..63 have sel 1, idx i−32, data ~(i−32).
  - `out_last` only on beat 63; `done` at cycle 66.
- Toggling backpressure: `out_ready` alternates 1/0 every cycle.
  - Expect the same 64 beats in order, with no duplicates or drops.
  - `out_*` stable during every stall.
- Long stall: hold `out_ready` = 0 for 10 cycles at beat 20.
  - Expect `out_data` = 60 held for the whole stall.
  - At most 2 reads issued past beat 20.
  - Streaming resumes at beat 21.
- Start while busy: pulse `start` again at cycle 10.
  - Expect exactly 64 beats and exactly one `done` pulse.
- Reset mid-dump: pull `rst_n` low at beat 30.
  - Expect all outputs 0 immediately.
  - A new `start` restarts at register 0 and produces 64 beats.
- Checksum build (`DUMP_CHECKSUM_EN` defined), baseline data:
  - Expect a 65th beat with sel 2 and data = XOR of beats 0..63, carrying `out_last`.
  - `done` at cycle 67.
